// File: rtl/alu_cmd_sequencer_if.sv
// Host/datapath bundle for the ALU command sequencer.
// master = the side driving commands and datapath control (host / bench),
// slave  = the sequencer itself.
interface alu_cmd_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_cmd;
  logic [2:0] in_rep;
  logic       stall;
  logic       flush;
  logic [1:0] sa;
  logic [1:0] sb;
  logic [3:0] so;
  logic       issue_valid;
  logic       busy;
  logic [2:0] fifo_count;

  modport master (
    output in_valid, in_cmd, in_rep, stall, flush,
    input  in_ready, sa, sb, so, issue_valid, busy, fifo_count
  );

  modport slave (
    input  in_valid, in_cmd, in_rep, stall, flush,
    output in_ready, sa, sb, so, issue_valid, busy, fifo_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: queues {cmd, rep} pairs in a small FIFO and issues
// each command on the registered ALU select lines for rep+1 cycles.
// Flush and reset both park the ALU on the RESET select pattern for a cycle.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  alu_cmd_sequencer_if.slave bus
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // Packed {sa, sb, so} select pattern for a given state and current command.
  function automatic logic [7:0] sel_pattern(input state_t st, input logic [4:0] c);
    logic [7:0] p;
    case (st)
      ST_FLUSH: p = 8'b10_11_1110;
      ST_IDLE:  p = 8'b00_00_0000;
      ST_ISSUE: p = {2'b01, c[4], 1'b1, c[3:0]};
      default:  p = 8'b10_11_1110;
    endcase
    return p;
  endfunction

  // FIFO pointer advance, wrapping modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // FIFO storage: each entry is {cmd[4:0], rep[2:0]}
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;

  // Sequencer state
  state_t        state_q, state_d;
  logic [4:0]    cur_q, cur_d;
  logic [2:0]    rem_q, rem_d;

  // Registered ALU selects
  logic [1:0]    sa_q, sb_q;
  logic [3:0]    so_q;
  logic          issue_valid_q;

  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    head_s;
  logic [7:0]    pat_s;

  assign in_ready_s = (count_q < DEPTH_C) && !bus.flush;
  assign push_s     = bus.in_valid && in_ready_s;
  assign head_s     = mem_q[rd_ptr_q];
  assign pat_s      = sel_pattern(state_d, cur_d);

  // Next-state decision: flush, then stall, then repeat, then pop, else idle.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    pop_s   = 1'b0;
    if (bus.flush) begin
      state_d = ST_FLUSH;
      rem_d   = 3'd0;
    end else if (bus.stall) begin
      state_d = state_q;
    end else if ((state_q == ST_ISSUE) && (rem_q != 3'd0)) begin
      rem_d   = rem_q - 3'd1;
      state_d = ST_ISSUE;
    end else if (count_q != 3'd0) begin
      pop_s   = 1'b1;
      cur_d   = head_s[7:3];
      rem_d   = head_s[2:0];
      state_d = ST_ISSUE;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // FIFO pointer and occupancy update; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = 3'd0;
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO entry storage; only written on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= {bus.in_cmd, bus.in_rep};
    end
  end

  // State, FIFO bookkeeping and registered select outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FLUSH;
      cur_q         <= 5'd0;
      rem_q         <= 3'd0;
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      count_q       <= 3'd0;
      sa_q          <= 2'b10;
      sb_q          <= 2'b11;
      so_q          <= 4'b1110;
      issue_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      rem_q         <= rem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      sa_q          <= pat_s[7:6];
      sb_q          <= pat_s[5:4];
      so_q          <= pat_s[3:0];
      issue_valid_q <= (state_d == ST_ISSUE);
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.sa          = sa_q;
  assign bus.sb          = sb_q;
  assign bus.so          = so_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.busy        = (state_q != ST_IDLE) || (count_q != 3'd0);
  assign bus.fifo_count  = count_q;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO depth in entries.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  host command valid.
REQ-005 The block SHALL have port in_ready  output  1  FIFO can accept a command.
REQ-006 The block SHALL have port in_cmd  input  5  ALU command (bit 4 selects B source, bits 3:0 opcode).
REQ-007 The block SHALL have port in_rep  input  3  repeat count; command issued in_rep+1 consecutive cycles.
REQ-008 The block SHALL have port stall  input  1  datapath hold request.
REQ-009 The block SHALL have port flush  input  1  synchronous flush request.
REQ-010 The block SHALL have port sa  output  2  ALU A-select, registered.
REQ-011 The block SHALL have port sb  output  2  ALU B-select, registered.
REQ-012 The block SHALL have port so  output  4  ALU op-select, registered.
REQ-013 The block SHALL have port issue_valid  output  1  a command is on sa/sb/so this cycle.
REQ-014 The block SHALL have port busy  output  1  state not IDLE or FIFO non-empty.
REQ-015 The block SHALL have port fifo_count  output  3  FIFO occupancy, 0..DEPTH.

Function
REQ-016 Output patterns SHALL be: RESET = sa 10, sb 11, so 1110; NOOP = sa 00, sb 00, so 0000; CMD(c) = sa 01, sb {c[4],1}, so c[3:0].
REQ-017 States SHALL be FLUSH (outputs RESET), IDLE (outputs NOOP), ISSUE (outputs CMD(cur)).
REQ-018 in_ready SHALL equal (fifo_count < DEPTH) AND NOT flush; push occurs on edge with in_valid AND in_ready.
REQ-019 Push SHALL be permitted regardless of stall and state; no bypass: entry pushed at edge k is poppable no earlier than edge k+1.
REQ-020 Per edge, first matching rule SHALL apply: (a) flush=1 -> clear FIFO, rem=0, state FLUSH; (b) stall=1 -> hold state, outputs, cur, rem, no pop; (c) state ISSUE and rem>0 -> rem-1, stay ISSUE; (d) FIFO non-empty -> pop head into cur, rem=head.rep, state ISSUE; (e) otherwise state IDLE.
REQ-021 Flush SHALL take priority over stall and over simultaneous push (push blocked by in_ready=0).
REQ-022 FLUSH SHALL last exactly one cycle unless flush remains asserted; then rules (c)-(e) resume.
REQ-023 Command accepted at edge k into an empty FIFO in IDLE with stall=0 SHALL appear on outputs after edge k+1 (one-cycle latency).
REQ-024 Back-to-back commands SHALL issue with no NOOP gap: last repeat cycle of one command is followed directly by CMD of the next.
REQ-025 issue_valid SHALL be 1 exactly when state is ISSUE, including stalled ISSUE cycles.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-027 Repeat counter SHALL be 3 bits; in_rep=7 yields 8 issue cycles, no overflow.

Reset
REQ-028 While rst=0: state FLUSH, outputs RESET pattern, issue_valid 0, fifo_count 0, rem 0, cur 0, in_ready 1 (if flush=0).
REQ-029 Reset assertion mid-issue SHALL abort immediately and discard all FIFO contents.
REQ-030 First edge after rst deasserts SHALL apply REQ-020 normally.

Verification
REQ-031 Reset release, no input -> sa/sb/so 10/11/1110 until first edge, then 00/00/0000, busy 0.
REQ-032 Push cmd 10101 rep 0 at edge k -> after k+1 outputs 01/11/0101 for one cycle, issue_valid 1, then NOOP.
REQ-033 Push 01010 rep 2 then 10011 rep 0 back-to-back -> 3 cycles 01/01/1010 then 1 cycle 01/11/0011, no gap.
REQ-034 Push 5 commands with stall=1 -> fifo_count 4, in_ready 0, fifth not accepted; release stall -> all four issue in order.
REQ-035 Stall mid-repeat (rep 3, stall after 2nd cycle for 3 cycles) -> outputs and issue_valid held, total 4 issue cycles.
REQ-036 flush with stall=1, in_valid=1, 3 entries queued -> next cycle RESET pattern, fifo_count 0, push dropped, then NOOP.
